mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the CPU's single 32-bit memory port between instruction fetch (port 0) and data access (port 1). It grants one requester at a time in round-robin order and holds the grant until the memory acknowledges. It drives the select that steers the shared 32-bit address and write-data 2:1 datapath. A watchdog aborts any transaction the memory never completes.

## Interface
- `TIMEOUT`, default 255: maximum cycles a granted transaction waits for `mem_ready` before abort; legal range 1..255.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `req0` / `req1` in 1: requests from port 0 (IF) and port 1 (MEM).
- `addr0` / `addr1` in 32: request addresses.
- `wdata0` / `wdata1` in 32: write data.
- `we0` / `we1` in 1: write enables; 0 means read.
- `ack0` / `ack1` out 1: one-cycle completion strobes.
- `err0` / `err1` out 1: one-cycle timeout-abort strobes.
- `rdata0` / `rdata1` out 32: read data, valid while the matching `ack` is high.
- `mem_req` out 1: request to memory.
- `mem_addr` out 32: address of the selected port.
- `mem_wdata` out 32: write data of the selected port.
- `mem_we` out 1: write enable, gated by `mem_req`.
- `mem_ready` in 1: memory completion.
- `mem_rdata` in 32: memory read data.
- `sel` out 1: datapath select; 0 selects port 0, 1 selects port 1.

## Operation
- States: IDLE, BUSY0, BUSY1.
- Registered state: `state`, `sel`, `last`, and an 8-bit `wait_cnt`. `last` records the port granted most recently.
- **IDLE**
  - Only `req0` high: go to BUSY0 and set `sel`=0.
  - Only `req1` high: go to BUSY1 and set `sel`=1.
  - Both high: grant the port not equal to `last`.
  - On any grant: `last` takes the granted port and `wait_cnt` clears to 0.
  - No request: stay in IDLE; `sel` holds its value.
- **BUSYx**
  - `mem_req`=1.
  - `mem_addr`, `mem_wdata` and `mem_we` follow port x combinationally through `sel`.
  - A requester must hold `req`, `addr`, `wdata` and `we` stable until its `ack` or `err`.
  - If `mem_ready`=1: `ackx`=1 in the same cycle, `rdatax`=`mem_rdata` in the same cycle, and the next state is IDLE.
  - Else, if `wait_cnt`==`TIMEOUT`-1: `errx`=1 and the next state is IDLE. The memory must treat a deasserted `mem_req` as cancellation.
  - Else `wait_cnt` increments.
  - If `reqx` drops while BUSYx, the transaction is abandoned: next state IDLE, no `ack`, no `err`.
- The off-port `rdata` output is 0. `ack` and `err` are never high together, and are never high for both ports.
- `mem_req`, `ack` and `err` are decoded from `state`; they are never registered outputs.
- Reset, including mid-transaction:
  - `state`=IDLE, `sel`=0, `last`=1 (port 0 wins the first tie), `wait_cnt`=0.
  - All outputs read 0: `mem_req`, `ack`, `err`, `rdata`, and `mem_we`. `mem_addr` and `mem_wdata` show port 0 because `sel`=0.

## Timing
- Request to `mem_req`: the request is seen in IDLE in cycle N; `mem_req`=1 from cycle N+1.
- Zero-wait memory: `mem_ready` high in cycle N+1 gives `ack` in N+1. Minimum latency is 1 cycle.
- Throughput: the mandatory IDLE cycle after every completion gives at most one transaction per 2 cycles.
- Sustained contention: grants alternate 0,1,0,1,… and neither port waits more than one foreign transaction.
- Timeout: with `mem_ready` never asserted, `err` pulses in the `TIMEOUT`-th BUSY cycle and `mem_req` falls in the next cycle.
- `mem_ready` in the same cycle as the final timeout count: completion wins, giving `ack` and no `err`.
- `mem_ready` while IDLE is ignored.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `req0`=`req1`=1. Required: `mem_req`=0, `sel`=0, and all `ack`/`err`=0. After release, the first grant goes to port 0.
- **Single read:** `req0`=1, `addr0`=0x0000_1000, `we0`=0; memory returns `mem_ready`=1 with 0xDEAD_BEEF one cycle after `mem_req`. Required: `mem_addr`=0x0000_1000, `ack0` for 1 cycle, `rdata0`=0xDEAD_BEEF, `rdata1`=0.
- **Contention:** `req0` and `req1` held high, port 1 writing 0x1234_5678 to 0x2000, memory with 2 wait states. Required:
  - grant order 0,1,0,1;
  - `sel` matches each grant;
  - `mem_wdata`=0x1234_5678 and `mem_we`=1 only during BUSY1;
  - each transaction 4 cycles including IDLE.
- **Timeout:** `TIMEOUT`=4, `req1`=1, `mem_ready` held at 0. Required: `err1` pulses in the 4th BUSY cycle, no `ack1`, `mem_req` low in the next cycle, and the following grant goes to port 0 if requested.
- **Race:** `TIMEOUT`=4 with `mem_ready`=1 in the 4th BUSY cycle. Required: `ack1`=1 and `err1`=0.
- **Mid-transaction reset and abandon:**
  - Assert `rst_n`=0 during BUSY0 with 3 wait states outstanding. Required: `mem_req`=0 in the next cycle, no `ack0`, `last`=1.
  - Separately, drop `req1` during BUSY1. Required: return to IDLE with no strobe.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : round-robin 2:1 arbiter for the shared 32-bit memory port
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        sel
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY0 = 2'd1;
    localparam logic [1:0] c_BUSY1 = 2'd2;

    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic       r_sel;
    logic       r_last;
    logic [7:0] r_wait_cnt;

    logic [1:0] w_next_state;
    logic       w_next_sel;
    logic       w_next_last;
    logic [7:0] w_next_cnt;
    logic       w_timeout;
    logic       w_busy0;
    logic       w_busy1;

    assign w_timeout = (r_wait_cnt == c_TO_LAST);
    assign w_busy0   = (r_state == c_BUSY0);
    assign w_busy1   = (r_state == c_BUSY1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_sel      <= 1'b0;
            r_last     <= 1'b1;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_sel      <= w_next_sel;
            r_last     <= w_next_last;
            r_wait_cnt <= w_next_cnt;
        end
    end

    // Next-state logic; a dropped request outranks completion and timeout
    always_comb begin
        w_next_state = r_state;
        w_next_sel   = r_sel;
        w_next_last  = r_last;
        w_next_cnt   = r_wait_cnt;
        case (r_state)
            c_IDLE: begin
                if (req0 && (!req1 || r_last)) begin
                    w_next_state = c_BUSY0;
                    w_next_sel   = 1'b0;
                    w_next_last  = 1'b0;
                    w_next_cnt   = 8'd0;
                end else if (req1) begin
                    w_next_state = c_BUSY1;
                    w_next_sel   = 1'b1;
                    w_next_last  = 1'b1;
                    w_next_cnt   = 8'd0;
                end
            end
            c_BUSY0, c_BUSY1: begin
                if (!(w_busy0 ? req0 : req1)) begin
                    w_next_state = c_IDLE;
                end else if (mem_ready || w_timeout) begin
                    w_next_state = c_IDLE;
                end else begin
                    w_next_cnt = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Output decode from state; strobes only while the owner still requests
    always_comb begin
        mem_req   = w_busy0 || w_busy1;
        ack0      = w_busy0 && req0 && mem_ready;
        ack1      = w_busy1 && req1 && mem_ready;
        err0      = w_busy0 && req0 && !mem_ready && w_timeout;
        err1      = w_busy1 && req1 && !mem_ready && w_timeout;
        rdata0    = ack0 ? mem_rdata : 32'd0;
        rdata1    = ack1 ? mem_rdata : 32'd0;
        sel       = r_sel;
        mem_addr  = r_sel ? addr1 : addr0;
        mem_wdata = r_sel ? wdata1 : wdata0;
        mem_we    = mem_req && (r_sel ? we1 : we0);
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        we0, we1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        sel;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .we0       (we0),
        .we1       (we1),
        .ack0      (ack0),
        .ack1      (ack1),
        .err0      (err0),
        .err1      (err1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes_quiet(input string tag);
        chk({tag, "_ack0"}, {31'd0, ack0}, 32'd0);
        chk({tag, "_ack1"}, {31'd0, ack1}, 32'd0);
        chk({tag, "_err0"}, {31'd0, err0}, 32'd0);
        chk({tag, "_err1"}, {31'd0, err1}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        addr0 = 32'h0000_0040; addr1 = 32'h0000_0080;
        wdata0 = 32'h0; wdata1 = 32'h0; we0 = 1'b0; we1 = 1'b1;
        mem_ready = 1'b0; mem_rdata = 32'h0;

        // Reset held three cycles with both requests pending
        tick(); tick(); tick();
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0000_0040);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        strobes_quiet("rst");

        // First tie after reset goes to port 0
        rst_n = 1'b1;
        tick();
        req1 = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
        #1;
        chk("first_sel", {31'd0, sel}, 32'd0);
        chk("first_mem_req", {31'd0, mem_req}, 32'd1);
        chk("first_ack0", {31'd0, ack0}, 32'd1);
        chk("first_rdata0", rdata0, 32'hA5A5_0001);
        tick();
        req0 = 1'b0; mem_ready = 1'b0;
        #1;
        chk("first_idle_mem_req", {31'd0, mem_req}, 32'd0);

        // Single read with one wait cycle
        req0 = 1'b1; addr0 = 32'h0000_1000; we0 = 1'b0;
        #1;
        chk("rd_idle_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("rd_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rd_mem_addr", mem_addr, 32'h0000_1000);
        chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rd_ack0_early", {31'd0, ack0}, 32'd0);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_ack0", {31'd0, ack0}, 32'd1);
        chk("rd_rdata0", rdata0, 32'hDEAD_BEEF);
        chk("rd_rdata1", rdata1, 32'd0);
        chk("rd_ack1", {31'd0, ack1}, 32'd0);
        tick();
        req0 = 1'b0; mem_ready = 1'b0;
        #1;
        chk("rd_done_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rd_done_ack0", {31'd0, ack0}, 32'd0);

        // Timeout on port 1 (TIMEOUT=4)
        req1 = 1'b1; addr1 = 32'h0000_2000; wdata1 = 32'h1234_5678; we1 = 1'b1;
        wdata0 = 32'h0;
        tick();
        chk("to_sel", {31'd0, sel}, 32'd1);
        chk("to_mem_req", {31'd0, mem_req}, 32'd1);
        chk("to_err1_c1", {31'd0, err1}, 32'd0);
        tick();
        chk("to_err1_c2", {31'd0, err1}, 32'd0);
        tick();
        chk("to_err1_c3", {31'd0, err1}, 32'd0);
        tick();
        req0 = 1'b1;
        #1;
        chk("to_err1_c4", {31'd0, err1}, 32'd1);
        chk("to_ack1_c4", {31'd0, ack1}, 32'd0);
        chk("to_err0_c4", {31'd0, err0}, 32'd0);
        tick();
        chk("to_after_mem_req", {31'd0, mem_req}, 32'd0);
        chk("to_after_err1", {31'd0, err1}, 32'd0);

        // Contention, two wait states: grants 0,1,0,1, four cycles each
        for (int t = 0; t < 4; t++) begin
            logic p;
            p = t[0];
            chk("ct_idle_mem_req", {31'd0, mem_req}, 32'd0);
            tick();
            chk("ct_sel", {31'd0, sel}, {31'd0, p});
            chk("ct_mem_req", {31'd0, mem_req}, 32'd1);
            chk("ct_mem_we", {31'd0, mem_we}, {31'd0, p});
            chk("ct_mem_wdata", mem_wdata, p ? 32'h1234_5678 : 32'h0);
            chk("ct_mem_addr", mem_addr, p ? 32'h0000_2000 : 32'h0000_1000);
            tick();
            chk("ct_wait_ack0", {31'd0, ack0}, 32'd0);
            chk("ct_wait_ack1", {31'd0, ack1}, 32'd0);
            tick();
            mem_ready = 1'b1;
            #1;
            chk("ct_ack0", {31'd0, ack0}, {31'd0, !p});
            chk("ct_ack1", {31'd0, ack1}, {31'd0, p});
            tick();
            mem_ready = 1'b0;
            #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("ct_end_mem_req", {31'd0, mem_req}, 32'd0);

        // Completion and final timeout count in the same cycle: ack wins
        req1 = 1'b1;
        tick(); tick(); tick(); tick();
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0004;
        #1;
        chk("race_ack1", {31'd0, ack1}, 32'd1);
        chk("race_err1", {31'd0, err1}, 32'd0);
        chk("race_rdata1", rdata1, 32'hCAFE_0004);
        tick();
        req1 = 1'b0; mem_ready = 1'b0;
        #1;
        chk("race_idle_mem_req", {31'd0, mem_req}, 32'd0);

        // Reset during BUSY0 with wait states outstanding
        req0 = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("mrst_ack0", {31'd0, ack0}, 32'd0);
        rst_n = 1'b1; req1 = 1'b1;
        tick();
        chk("mrst_tie_sel", {31'd0, sel}, 32'd0);
        chk("mrst_tie_mem_req", {31'd0, mem_req}, 32'd1);

        // Abandon port 0, then abandon port 1 even with mem_ready high
        req0 = 1'b0;
        #1;
        strobes_quiet("ab0");
        tick();
        chk("ab0_idle_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("ab1_sel", {31'd0, sel}, 32'd1);
        chk("ab1_mem_req", {31'd0, mem_req}, 32'd1);
        req1 = 1'b0; mem_ready = 1'b1;
        #1;
        strobes_quiet("ab1");
        tick();
        chk("ab1_idle_mem_req", {31'd0, mem_req}, 32'd0);
        strobes_quiet("idle_ready");
        tick();
        chk("idle_ready_mem_req", {31'd0, mem_req}, 32'd0);
        mem_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
